// File: rtl/openmips_intc_if.sv
// openmips_intc_if
//   Core data-bus view of the interrupt controller. The core side (master)
//   drives the ram_* request fields and receives the read data and the
//   address-hit flag, which the core uses to choose between RAM and controller
//   read data.
//   ce_i    access enable          we_i    1 = write, 0 = read
//   addr_i  byte address           sel_i   byte-lane select
//   data_i  write data             data_o  read data (controller -> core)
//   hit_o   address hit in the register window (controller -> core)
interface openmips_intc_if;
   logic        ce_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [3:0]  sel_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        hit_o;

   modport master (output ce_i, we_i, addr_i, sel_i, data_i,
                   input  data_o, hit_o);
   modport slave  (input  ce_i, we_i, addr_i, sel_i, data_i,
                   output data_o, hit_o);
endinterface

// File: rtl/openmips_intc.sv
// openmips_intc
//   External interrupt controller placed in front of the OpenMIPS int_i port.
//   Each source is synchronised, normalised by polarity, turned into a pending
//   flag (level follows the line, edge latches until write-1-to-clear), masked
//   and registered onto int_o.
//   clk    system clock
//   rst    asynchronous reset, active-low
//   irq_i  raw asynchronous device lines
//   bus    register window on the core data bus (slave side)
//   int_o  registered requests, wired to int_i[NUM_SRC:1]
//   Register map (offset = addr[4:0]): 0x00 PEND (R/W1C), 0x04 MASK, 0x08 MODE
//   (1 = edge), 0x0C POL (1 = active-high), 0x10 STATUS = PEND & MASK (RO).

// One source: 2-flop synchroniser, polarity normalisation, pending flag.
module openmips_intc_lane (
   input  logic clk,
   input  logic rst,
   input  logic irq,
   input  logic pol,
   input  logic mode,
   input  logic w1c,
   output logic pend
);
   logic s1, s2, prev, act;

   assign act = s2 ~^ pol;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
         pend <= 1'b0;
      end else begin
         s1   <= irq;
         s2   <= s1;
         prev <= act;
         if (mode) begin
            // a new edge beats a simultaneous software clear
            if (act && !prev)
               pend <= 1'b1;
            else if (w1c)
               pend <= 1'b0;
         end else begin
            pend <= act;
         end
      end
   end
endmodule

module openmips_intc #(
   parameter int          NUM_SRC   = 5,
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_SRC-1:0] irq_i,
   openmips_intc_if.slave     bus,
   output logic [NUM_SRC-1:0] int_o
);
   localparam logic [4:0] OFF_PEND   = 5'h00;
   localparam logic [4:0] OFF_MASK   = 5'h04;
   localparam logic [4:0] OFF_MODE   = 5'h08;
   localparam logic [4:0] OFF_POL    = 5'h0C;
   localparam logic [4:0] OFF_STATUS = 5'h10;

   logic [NUM_SRC-1:0] pend, mask, mode, pol, w1c, wdata;
   logic [4:0]         off;
   logic               wr_en;
   logic [31:0]        rdata;

   // upper write-data bits and sel[3:1] carry nothing for this block
   logic unused_bits;
   assign unused_bits = ^{bus.data_i[31:NUM_SRC], bus.sel_i[3:1]};

   assign bus.hit_o = bus.ce_i & (bus.addr_i[31:5] == BASE_ADDR[31:5]);
   assign off       = bus.addr_i[4:0];
   assign wdata     = bus.data_i[NUM_SRC-1:0];
   assign wr_en     = bus.hit_o & bus.we_i & bus.sel_i[0];
   assign w1c       = (wr_en && off == OFF_PEND) ? wdata : '0;

   openmips_intc_lane u_lane [NUM_SRC-1:0] (
      .clk  (clk),
      .rst  (rst),
      .irq  (irq_i),
      .pol  (pol),
      .mode (mode),
      .w1c  (w1c),
      .pend (pend)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask  <= '0;
         mode  <= '0;
         pol   <= '1;
         int_o <= '0;
      end else begin
         int_o <= pend & mask;
         if (wr_en) begin
            case (off)
               OFF_MASK: mask <= wdata;
               OFF_MODE: mode <= wdata;
               OFF_POL:  pol  <= wdata;
               default:  ;
            endcase
         end
      end
   end

   // zero-wait read; returns 0 whenever the core is not reading this window
   always_comb begin
      rdata = '0;
      if (bus.hit_o && !bus.we_i) begin
         case (off)
            OFF_PEND:   rdata[NUM_SRC-1:0] = pend;
            OFF_MASK:   rdata[NUM_SRC-1:0] = mask;
            OFF_MODE:   rdata[NUM_SRC-1:0] = mode;
            OFF_POL:    rdata[NUM_SRC-1:0] = pol;
            OFF_STATUS: rdata[NUM_SRC-1:0] = pend & mask;
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.data_o = rdata;
endmodule

// File: tb/tb_openmips_intc.sv
module tb_openmips_intc;
   localparam int          N    = 5;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [N-1:0] irq = '0;
   logic [N-1:0] int_o;
   int           checks = 0;
   int           errors = 0;

   // reference model state
   logic [N-1:0] m_pend, m_mask, m_mode, m_pol, m_int, m_last_act;
   logic [N-1:0] hist [$];

   openmips_intc_if bus ();

   openmips_intc #(.NUM_SRC(N), .BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .rst   (rst),
      .irq_i (irq),
      .bus   (bus),
      .int_o (int_o)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.ce_i = 1'b0;
      bus.we_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic bus_write(input logic [4:0] off, input logic [31:0] d, input logic [3:0] sel);
      @(negedge clk);
      bus.ce_i = 1'b1; bus.we_i = 1'b1;
      bus.addr_i = BASE + {27'h0, off}; bus.data_i = d; bus.sel_i = sel;
      @(posedge clk); #1;
      bus.ce_i = 1'b0; bus.we_i = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic h);
      @(negedge clk);
      bus.ce_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = addr; bus.sel_i = 4'hF;
      #1;
      d = bus.data_o; h = bus.hit_o;
      bus.ce_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic h;
      irq = 5'h1F;
      rst = 1'b0;
      #1;
      checks++; if (int_o !== 5'h00) begin errors++; $display("FAIL reset_int got %h exp 00", int_o); end
      bus_read(BASE + 32'h04, d, h);
      checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL reset_mask got %h hit %b exp 0 hit 1", d, h); end
      bus_read(BASE + 32'h08, d, h);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_mode got %h exp 0", d); end
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_pend got %h exp 0", d); end
      bus_read(BASE + 32'h0C, d, h);
      checks++; if (d !== 32'h1F) begin errors++; $display("FAIL reset_pol got %h exp 1f", d); end
      irq = '0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_level();
      irq = '0;
      do_reset();
      bus_write(5'h04, 32'h1, 4'hF);
      @(negedge clk); irq[0] = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++; if (int_o[0] !== 1'b0) begin errors++; $display("FAIL level_rise_early got %b exp 0", int_o[0]); end
      @(posedge clk); #1;
      checks++; if (int_o[0] !== 1'b1) begin errors++; $display("FAIL level_rise got %b exp 1", int_o[0]); end
      @(negedge clk); irq[0] = 1'b0;
      repeat (3) @(posedge clk); #1;
      checks++; if (int_o[0] !== 1'b1) begin errors++; $display("FAIL level_fall_early got %b exp 1", int_o[0]); end
      @(posedge clk); #1;
      checks++; if (int_o[0] !== 1'b0) begin errors++; $display("FAIL level_fall got %b exp 0", int_o[0]); end
      // asynchronous drop of int_o on reset, no clock edge in between
      @(negedge clk); irq[0] = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (int_o[0] !== 1'b1) begin errors++; $display("FAIL level_hold got %b exp 1", int_o[0]); end
      #2 rst = 1'b0;
      #1;
      checks++; if (int_o !== 5'h00) begin errors++; $display("FAIL async_reset got %h exp 00", int_o); end
      irq = '0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_edge_w1c();
      logic [31:0] d; logic h;
      irq = '0;
      do_reset();
      bus_write(5'h08, 32'h04, 4'hF);
      bus_write(5'h04, 32'h04, 4'hF);
      @(negedge clk); irq[2] = 1'b1;
      repeat (3) @(negedge clk); irq[2] = 1'b0;
      repeat (6) @(negedge clk);
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h04) begin errors++; $display("FAIL edge_pend got %h exp 04", d); end
      checks++; if (int_o !== 5'h04) begin errors++; $display("FAIL edge_int got %h exp 04", int_o); end
      bus_write(5'h00, 32'h04, 4'hF);
      checks++; if (int_o[2] !== 1'b1) begin errors++; $display("FAIL w1c_first got %b exp 1", int_o[2]); end
      @(posedge clk); #1;
      checks++; if (int_o[2] !== 1'b0) begin errors++; $display("FAIL w1c_second got %b exp 0", int_o[2]); end
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL w1c_pend got %h exp 0", d); end
   endtask

   task automatic test_set_vs_clear();
      logic [31:0] d; logic h;
      irq = '0;
      do_reset();
      bus_write(5'h08, 32'h02, 4'hF);
      @(negedge clk); irq[1] = 1'b1;
      @(posedge clk);
      @(posedge clk);
      bus_write(5'h00, 32'h02, 4'hF);   // lands on the edge's PEND posedge
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL set_wins got %h exp 02", d); end
      bus_write(5'h00, 32'h02, 4'hF);
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h0) begin errors++; $display("FAIL clear_after got %h exp 0", d); end
   endtask

   task automatic test_pol_mask();
      logic [31:0] d; logic h;
      irq = '0;
      do_reset();
      bus_write(5'h0C, 32'h1D, 4'hF);
      repeat (4) @(negedge clk);
      bus_read(BASE + 32'h00, d, h);
      checks++; if (d !== 32'h02) begin errors++; $display("FAIL pol_pend got %h exp 02", d); end
      checks++; if (int_o !== 5'h00) begin errors++; $display("FAIL masked_int got %h exp 00", int_o); end
      bus_write(5'h04, 32'h02, 4'hF);
      checks++; if (int_o !== 5'h00) begin errors++; $display("FAIL unmask_first got %h exp 00", int_o); end
      @(posedge clk); #1;
      checks++; if (int_o !== 5'h02) begin errors++; $display("FAIL unmask_second got %h exp 02", int_o); end
   endtask

   task automatic test_decode();
      logic [31:0] d; logic h;
      irq = '0;
      do_reset();
      bus_read(BASE + 32'h14, d, h);
      checks++; if (d !== 32'h0 || h !== 1'b1) begin errors++; $display("FAIL dec_0x14 got %h hit %b exp 0 hit 1", d, h); end
      bus_write(5'h04, 32'h05, 4'hF);
      bus_write(5'h04, 32'h1A, 4'b1110);
      bus_read(BASE + 32'h04, d, h);
      checks++; if (d !== 32'h05) begin errors++; $display("FAIL dec_sel got %h exp 05", d); end
      bus_read(BASE + 32'h20, d, h);
      checks++; if (d !== 32'h0 || h !== 1'b0) begin errors++; $display("FAIL dec_miss got %h hit %b exp 0 hit 0", d, h); end
   endtask

   // one clock of random traffic; the model advances at the same posedge
   task automatic step(input bit wr, input bit rd, input logic [4:0] off, input logic [31:0] wd,
                       input logic [3:0] sel, input logic [N-1:0] irqv);
      logic [31:0]  exp_rd;
      logic [N-1:0] act, w1c, np;
      @(negedge clk);
      irq = irqv;
      bus.ce_i = wr | rd; bus.we_i = wr;
      bus.addr_i = BASE + {27'h0, off}; bus.data_i = wd; bus.sel_i = sel;
      if (rd) begin
         #1;
         exp_rd = '0;
         case (off)
            5'h00: exp_rd[N-1:0] = m_pend;
            5'h04: exp_rd[N-1:0] = m_mask;
            5'h08: exp_rd[N-1:0] = m_mode;
            5'h0C: exp_rd[N-1:0] = m_pol;
            5'h10: exp_rd[N-1:0] = m_pend & m_mask;
            default: exp_rd = '0;
         endcase
         checks++;
         if (bus.data_o !== exp_rd) begin errors++; $display("FAIL rand_read off %h got %h exp %h", off, bus.data_o, exp_rd); end
      end
      @(posedge clk);
      // line value seen two clocks ago, normalised by the current polarity
      act = hist[hist.size()-2] ~^ m_pol;
      w1c = (wr && sel[0] && off == 5'h00) ? wd[N-1:0] : '0;
      m_int = m_pend & m_mask;
      for (int i = 0; i < N; i++) begin
         if (m_mode[i])
            np[i] = (act[i] && !m_last_act[i]) ? 1'b1 : (w1c[i] ? 1'b0 : m_pend[i]);
         else
            np[i] = act[i];
      end
      m_pend = np;
      m_last_act = act;
      if (wr && sel[0]) begin
         case (off)
            5'h04: m_mask = wd[N-1:0];
            5'h08: m_mode = wd[N-1:0];
            5'h0C: m_pol  = wd[N-1:0];
            default: ;
         endcase
      end
      hist.push_back(irqv);
      if (hist.size() > 4) void'(hist.pop_front());
      #1;
      bus.ce_i = 1'b0; bus.we_i = 1'b0;
      checks++;
      if (int_o !== m_int) begin errors++; $display("FAIL rand_int got %h exp %h", int_o, m_int); end
   endtask

   task automatic test_random();
      logic [4:0]   offs [6];
      logic [N-1:0] irqv;
      int           r;
      offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10, 5'h14};
      irq = '0;
      do_reset();
      m_pend = '0; m_mask = '0; m_mode = '0; m_pol = '1; m_int = '0; m_last_act = '0;
      hist.delete();
      hist.push_back('0); hist.push_back('0);
      for (int k = 0; k < 600; k++) begin
         r = $urandom_range(0, 7);
         irqv = irq ^ N'($urandom & $urandom);
         step(r == 0, r == 1 || r == 2, offs[$urandom_range(0, 5)], $urandom,
              ($urandom_range(0, 3) == 0) ? 4'hE : 4'hF, irqv);
      end
   endtask

   initial begin
      bus.ce_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.sel_i = '0; bus.data_i = '0;
      test_reset();
      test_level();
      test_edge_w1c();
      test_set_vs_clear();
      test_pol_mask();
      test_decode();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
